// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, held imem request, one-entry skid buffer, branch redirect.
// Define PC_MISALIGN_TRAP_EN to redirect misaligned branch targets to TRAP_PC and report them.
module if_stage #(
   parameter int unsigned  N        = 32,
   parameter logic [N-1:0] RESET_PC = '0
`ifdef PC_MISALIGN_TRAP_EN
   ,
   parameter logic [N-1:0] TRAP_PC  = N'(32'h0000_0100)
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_ack,
   input  logic [N-1:0] imem_rdata,
   output logic [N-1:0] instruction_out,
   output logic [N-1:0] pc_out,
   output logic         valid_out,
`ifdef PC_MISALIGN_TRAP_EN
   output logic         misalign_out,
   output logic [N-1:0] badaddr_out,
`endif
   output logic         flush
);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

   state_e       state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] drop_addr_q, drop_addr_d;
   logic         pend_q, pend_d;
   logic         valid_q, valid_d;
   logic [N-1:0] instr_q, instr_d;
   logic [N-1:0] pc_out_q, pc_out_d;
   logic         skid_full_q, skid_full_d;
   logic [N-1:0] skid_instr_q, skid_instr_d;
   logic [N-1:0] skid_pc_q, skid_pc_d;
   logic         slot_free, skid_drain, word_in;
   logic [N-1:0] redirect_pc;
`ifdef PC_MISALIGN_TRAP_EN
   logic         misalign_q, misalign_d;
   logic [N-1:0] badaddr_q, badaddr_d;
   logic         misaligned;
`endif

   // Request side: a request, once raised, is held by pend_q until it is acknowledged.
   always_comb begin
      slot_free  = !valid_q || !stall;
      skid_drain = skid_full_q && slot_free;
      imem_req   = 1'b0;
      unique case (state_q)
         REQ:     imem_req = pend_q || !skid_full_q || skid_drain;
         DROP:    imem_req = 1'b1;
         default: imem_req = 1'b0;
      endcase
      if (rst) begin
         imem_req = 1'b0;
      end
      imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
      word_in   = (state_q == REQ) && imem_req && imem_ack;
   end

   always_comb begin
      // NOTE: every output of this block is given a default first, so no path can infer a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      drop_addr_d  = drop_addr_q;
      pend_d       = pend_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc_out_d     = pc_out_q;
      skid_full_d  = skid_full_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_d   = 1'b0;
      badaddr_d    = badaddr_q;
      misaligned   = (branch_target[1:0] != 2'b00);
      redirect_pc  = misaligned ? TRAP_PC : branch_target;
`else
      redirect_pc  = branch_target & ~N'(3);
`endif

      unique case (state_q)
         IDLE: state_d = REQ;
         REQ, DROP: begin
            if (branch_taken) begin
               pc_d        = redirect_pc;
               valid_d     = 1'b0;
               skid_full_d = 1'b0;
               pend_d      = 1'b0;
               // An unanswered request must still be retired, so its ack is absorbed in DROP.
               if (state_q == REQ && imem_req && !imem_ack) begin
                  state_d     = DROP;
                  drop_addr_d = pc_q;
               end else if (state_q == DROP && imem_ack) begin
                  state_d = REQ;
               end
`ifdef PC_MISALIGN_TRAP_EN
               if (misaligned) begin
                  misalign_d = 1'b1;
                  badaddr_d  = branch_target;
               end
`endif
            end else begin
               if (state_q == DROP && imem_ack) begin
                  state_d = REQ;
               end
               if (state_q == REQ) begin
                  pend_d = imem_req && !imem_ack;
               end
               if (word_in) begin
                  pc_d = pc_q + N'(4);
                  if (skid_full_q) begin
                     instr_d      = skid_instr_q;
                     pc_out_d     = skid_pc_q;
                     valid_d      = 1'b1;
                     skid_instr_d = imem_rdata;
                     skid_pc_d    = pc_q;
                  end else if (slot_free) begin
                     instr_d  = imem_rdata;
                     pc_out_d = pc_q;
                     valid_d  = 1'b1;
                  end else begin
                     skid_instr_d = imem_rdata;
                     skid_pc_d    = pc_q;
                     skid_full_d  = 1'b1;
                  end
               end else if (slot_free) begin
                  if (skid_full_q) begin
                     instr_d     = skid_instr_q;
                     pc_out_d    = skid_pc_q;
                     valid_d     = 1'b1;
                     skid_full_d = 1'b0;
                  end else begin
                     valid_d = 1'b0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         drop_addr_q <= '0;
         pend_q      <= 1'b0;
         valid_q     <= 1'b0;
         instr_q     <= '0;
         pc_out_q    <= '0;
         skid_full_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
         misalign_q  <= 1'b0;
         badaddr_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         pend_q      <= pend_d;
         valid_q     <= valid_d;
         instr_q     <= instr_d;
         pc_out_q    <= pc_out_d;
         skid_full_q <= skid_full_d;
`ifdef PC_MISALIGN_TRAP_EN
         misalign_q  <= misalign_d;
         badaddr_q   <= badaddr_d;
`endif
      end
   end

   // NOTE: the skid payload has no reset; skid_full_q qualifies it, so its contents never matter when empty.
   always_ff @(posedge clk) begin
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
   end

   assign instruction_out = instr_q;
   assign pc_out          = pc_out_q;
   assign valid_out       = valid_q;
   assign flush           = branch_taken;
`ifdef PC_MISALIGN_TRAP_EN
   assign misalign_out    = misalign_q;
   assign badaddr_out     = badaddr_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run against a
// scoreboard that expects consecutive word addresses from every reset/redirect point.
module tb_if_stage;

   localparam int          N        = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instruction_out;
   logic [31:0] pc_out;
   logic        valid_out;
   logic        flush;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign_out;
   logic [31:0] badaddr_out;
`endif

   if_stage #(.N(N), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instruction_out(instruction_out),
      .pc_out         (pc_out),
      .valid_out      (valid_out),
`ifdef PC_MISALIGN_TRAP_EN
      .misalign_out   (misalign_out),
      .badaddr_out    (badaddr_out),
`endif
      .flush          (flush)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: every word is the complement of its address.
   assign imem_rdata = imem_addr ^ 32'hFFFF_FFFF;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] next_pc;
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_sb  = 0;
   int          ack_mode = 0;   // 0: ack tied high, 1: random latency, 2: manual
   logic        ack_man  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_redirect(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
      return (t % 4 != 0) ? TRAP_PC : t;
`else
      return t - (t % 4);
`endif
   endfunction

   task automatic sb_top_up();
      while (exp_q.size() < 64) begin
         exp_q.push_back('{pc: next_pc, ins: next_pc ^ 32'hFFFF_FFFF});
         next_pc = next_pc + 32'd4;
      end
   endtask

   task automatic sb_reset(input logic [31:0] start);
      exp_q.delete();
      next_pc = start;
      sb_top_up();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sb_top_up();
   endtask

   // Memory responder: updates ack 2 time units after each edge, after stimulus has settled.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      imem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (ack_mode == 0) begin
            imem_ack = 1'b1;
         end else if (ack_mode == 2) begin
            imem_ack = ack_man;
         end else if (imem_req && wait_cnt == 0) begin
            imem_ack = 1'b1;
            wait_cnt = int'($urandom_range(0, 3));
         end else begin
            imem_ack = 1'b0;
            if (imem_req && wait_cnt > 0) wait_cnt--;
         end
      end
   end

   // Monitor: a consumption happens at the coming edge when valid_out=1, stall=0 and no flush.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && valid_out === 1'b1 && stall === 1'b0 && branch_taken === 1'b0) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_underflow: got pc %h with no expected entry at %0t", pc_out, $time);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", pc_out, e.pc);
               check("sb_instr", instruction_out, e.ins);
               n_sb++;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got time %0t expected below 400000", $time);
      $fatal(1);
   end

   initial begin
      logic [31:0] held_pc, held_ins, tgt;
      int          sb_before;
      logic        prev_rst;
      int unsigned r;

      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      sb_reset(RESET_PC);
      repeat (3) tick();
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_instr", instruction_out, 32'd0);
      check("rst_pc_out", pc_out, 32'd0);
      check("rst_req", 32'(imem_req), 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
      check("rst_misalign", 32'(misalign_out), 32'd0);
      check("rst_badaddr", badaddr_out, 32'd0);
`endif

      // Release: one IDLE cycle, then the first request at RESET_PC.
      rst = 1'b0;
      #1;
      check("idle_req", 32'(imem_req), 32'd0);
      tick();
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, RESET_PC);
      tick();
      check("first_valid", 32'(valid_out), 32'd1);
      check("first_pc_out", pc_out, 32'h0);
      check("first_instr", instruction_out, 32'hFFFF_FFFF);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("stream_pc_out", pc_out, 32'(4 * k));
      end

      // Stall for three cycles: slot holds, one word parks in the skid, request drops.
      held_pc  = pc_out;
      held_ins = instruction_out;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_pc_hold", pc_out, held_pc);
         check("stall_ins_hold", instruction_out, held_ins);
         check("stall_req_drop", 32'(imem_req), 32'd0);
      end
      stall = 1'b0;
      #1;
      check("unstall_req", 32'(imem_req), 32'd1);
      tick();
      check("unstall_pc1", pc_out, held_pc + 32'd4);
      tick();
      check("unstall_pc2", pc_out, held_pc + 32'd8);

      // Redirect while a request to 0x10 waits for its ack.
      branch_taken = 1'b1; branch_target = 32'h10;
      sb_reset(exp_redirect(32'h10));
      tick();
      branch_taken = 1'b0;
      ack_mode = 2; ack_man = 1'b0;
      #1;
      check("flush_low", 32'(flush), 32'd0);
      check("pend_addr0", imem_addr, 32'h10);
      check("pend_req0", 32'(imem_req), 32'd1);
      tick();
      check("pend_addr1", imem_addr, 32'h10);
      branch_taken = 1'b1; branch_target = 32'h40;
      sb_reset(exp_redirect(32'h40));
      #1;
      check("flush_high", 32'(flush), 32'd1);
      tick();
      branch_taken = 1'b0;
      check("drop_addr0", imem_addr, 32'h10);
      check("drop_req0", 32'(imem_req), 32'd1);
      check("drop_valid0", 32'(valid_out), 32'd0);
      tick();
      check("drop_addr1", imem_addr, 32'h10);
      ack_man = 1'b1;
      tick();
      check("post_drop_addr", imem_addr, 32'h40);
      check("post_drop_valid", 32'(valid_out), 32'd0);
      check("post_drop_req", 32'(imem_req), 32'd1);
      ack_mode = 0;
      tick();
      check("redir_valid", 32'(valid_out), 32'd1);
      check("redir_pc_out", pc_out, 32'h40);
      check("redir_instr", instruction_out, 32'h40 ^ 32'hFFFF_FFFF);

      // Redirect coinciding with stall and ack while the skid holds a word.
      stall = 1'b1;
      tick();
      branch_taken = 1'b1; branch_target = 32'h80;
      sb_reset(exp_redirect(32'h80));
      tick();
      branch_taken = 1'b0; stall = 1'b0;
      #1;
      check("bsa_valid", 32'(valid_out), 32'd0);
      check("bsa_addr", imem_addr, 32'h80);
      check("bsa_req", 32'(imem_req), 32'd1);
      tick();
      check("bsa_pc_out", pc_out, 32'h80);

      // Address wrap at the top of the space.
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
      sb_reset(exp_redirect(32'hFFFF_FFFC));
      tick();
      branch_taken = 1'b0;
      check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_addr1", imem_addr, 32'h0);
      check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
      tick();

      // Misaligned branch target.
      branch_taken = 1'b1; branch_target = 32'h22;
      sb_reset(exp_redirect(32'h22));
      tick();
      branch_taken = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      check("mis_pulse", 32'(misalign_out), 32'd1);
      check("mis_badaddr", badaddr_out, 32'h22);
      check("mis_addr", imem_addr, 32'h100);
      tick();
      check("mis_pulse_end", 32'(misalign_out), 32'd0);
      check("mis_badaddr_hold", badaddr_out, 32'h22);
`else
      check("mis_addr", imem_addr, 32'h20);
      tick();
`endif
      tick();

      // Reset with a request in flight; the late ack must not produce a word.
      ack_mode = 2; ack_man = 1'b0;
      tick();
      rst = 1'b1;
      sb_reset(RESET_PC);
      tick();
      check("rip_req", 32'(imem_req), 32'd0);
      check("rip_valid", 32'(valid_out), 32'd0);
      ack_man = 1'b1;
      rst = 1'b0;
      tick();
      check("rip_idle_valid", 32'(valid_out), 32'd0);
      check("rip_addr", imem_addr, RESET_PC);
      ack_mode = 0;
      tick();
      check("rip_first_valid", 32'(valid_out), 32'd1);
      check("rip_first_pc", pc_out, RESET_PC);

      // Randomized phase: random ack latency, stalls, redirects and occasional resets.
      ack_mode  = 1;
      prev_rst  = 1'b0;
      sb_before = n_sb;
      for (int c = 0; c < 3000; c++) begin
         tick();
         prev_rst     = rst;
         rst          = 1'b0;
         branch_taken = 1'b0;
         stall        = ($urandom_range(0, 99) < 30);
         r            = $urandom_range(0, 199);
         if (r < 2 && !prev_rst) begin
            rst = 1'b1;
            sb_reset(RESET_PC);
         end else if (r < 12 && !prev_rst) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt = tgt - (tgt % 4);
            branch_taken  = 1'b1;
            branch_target = tgt;
            sb_reset(exp_redirect(tgt));
         end
      end
      rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      ack_mode = 0;
      repeat (8) tick();
      check("rand_progress", 32'(n_sb - sb_before > 200), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
